// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the pattern value loaded into the pattern register at reset.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/pattern_tx_down_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count never wraps below zero.
module down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, rep times,
// with optional idle gaps, over a valid/ready bit stream.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               REP_W   = 8,
  parameter int               GAP_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  state_t             state, state_n;
  logic [PAT_W-1:0]   pat_r;
  logic [GAP_W-1:0]   gap_r;
  logic               capture;

  logic [IDX_W-1:0]   bit_idx;
  logic [REP_W-1:0]   reps_left;
  logic [GAP_W-1:0]   gap_cnt;
  logic               bit_zero, reps_zero, gap_zero;
  logic               bit_load, bit_dec, reps_load, reps_dec, gap_load, gap_dec;
  logic               reps_last, gap_last;

  down_cnt #(.W(IDX_W)) u_bit_idx (
    .clk(clk), .rst(rst), .load(bit_load), .load_val(IDX_MAX),
    .dec(bit_dec), .count(bit_idx), .zero(bit_zero)
  );

  down_cnt #(.W(REP_W)) u_reps_left (
    .clk(clk), .rst(rst), .load(reps_load), .load_val(rep),
    .dec(reps_dec), .count(reps_left), .zero(reps_zero)
  );

  down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_r),
    .dec(gap_dec), .count(gap_cnt), .zero(gap_zero)
  );

  // Treating a zero count as "last" keeps the FSM from sticking if a counter
  // is ever observed at zero where a one was expected.
  assign reps_last = reps_zero || (reps_left == REP_W'(1));
  assign gap_last  = gap_zero  || (gap_cnt   == GAP_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pat_r <= DEF_PAT;
      gap_r <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        pat_r <= pattern;
        gap_r <= gap;
      end
    end
  end

  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    bit_load  = 1'b0;
    bit_dec   = 1'b0;
    reps_load = 1'b0;
    reps_dec  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (rep != '0) begin
            bit_load  = 1'b1;
            reps_load = 1'b1;
            state_n   = SEND;
          end else begin
            state_n = DONE;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!bit_zero) begin
            bit_dec = 1'b1;
          end else if (reps_last) begin
            state_n = DONE;
          end else begin
            reps_dec = 1'b1;
            bit_load = 1'b1;
            if (gap_r != '0) begin
              gap_load = 1'b1;
              state_n  = GAP;
            end
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_last) state_n = SEND;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign out_valid = (state == SEND);
  assign out_bit   = (state == SEND) ? pat_r[bit_idx] : 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: the driver queues each accepted request and
// a negedge monitor checks the bit stream, gaps and done timing against it.
module tb_pattern_tx;

  localparam int PAT_W = 4;
  localparam int REP_W = 8;
  localparam int GAP_W = 4;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] rep;
  logic [GAP_W-1:0] gap;
  logic             out_bit, out_valid, out_ready, busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stall_at  = -100;
  int stall_len = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [PAT_W-1:0] pat;
    int               rep;
    int               gap;
    int               acc;
  } txn_t;

  txn_t sb[$];

  pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .rep(rep),
    .gap(gap), .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Sink back-pressure: scripted stall window, else random or always ready.
  always @(posedge clk) begin
    #1;
    if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  // Monitor: expected stream is the pattern MSB-first, repeated rep times.
  bit   active = 1'b0;
  bit   want_done = 1'b0;
  bit   boundary = 1'b0;
  int   gap_run = 0;
  bit   exp_bits[$];
  txn_t cur;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      want_done = 1'b0;
      boundary = 1'b0;
      sb.delete();
      exp_bits.delete();
    end else begin
      if (!active && sb.size() > 0 && cyc >= sb[0].acc) begin
        cur = sb.pop_front();
        active = 1'b1;
        exp_bits.delete();
        for (int r = 0; r < cur.rep; r++)
          for (int i = PAT_W - 1; i >= 0; i--) exp_bits.push_back(cur.pat[i]);
        want_done = (cur.rep == 0);
        boundary = 1'b0;
        gap_run = 0;
      end
      if (!active) begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_valid", out_valid, 0);
      end else if (want_done) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("done_valid", out_valid, 0);
        checkOutput("done_busy", busy, 1);
        active = 1'b0;
        want_done = 1'b0;
      end else begin
        checkOutput("busy", busy, 1);
        checkOutput("early_done", done, 0);
        if (out_valid) begin
          if (boundary) begin
            checkOutput("gap_len", gap_run, cur.gap);
            boundary = 1'b0;
          end
          checkOutput("out_bit", out_bit, int'(exp_bits[0]));
          if (out_ready) begin
            void'(exp_bits.pop_front());
            if (exp_bits.size() == 0) want_done = 1'b1;
            else if (exp_bits.size() % PAT_W == 0) begin
              boundary = 1'b1;
              gap_run = 0;
            end
          end
        end else begin
          checkOutput("gap_bit_zero", out_bit, 0);
          if (boundary) gap_run++;
          else checkOutput("valid_drop", out_valid, 1);
        end
      end
    end
  end

  // Issue one request from an idle DUT (called at posedge+1) and wait for done;
  // with junk set, extra starts are pulsed while busy and must be ignored.
  task automatic applyStimulus(input logic [PAT_W-1:0] p, input int r, input int g,
                               input bit junk);
    bit seen = 1'b0;
    start = 1'b1;
    pattern = p;
    rep = REP_W'(r);
    gap = GAP_W'(g);
    sb.push_back('{p, r, g, cyc + 1});
    for (int n = 0; n < BUDGET && !seen; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        if (junk) begin
          start = 1'b1;
          pattern = 4'b0110;
        end
      end else if (junk && busy && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        pattern = 4'b0110;
        rep = REP_W'($urandom_range(0, 9));
        gap = GAP_W'($urandom_range(0, 15));
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pattern = '0;
    rep = '0;
    gap = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_bit", out_bit, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(4'b1010, 2, 0, 1'b0);
    applyStimulus(4'b1010, 2, 3, 1'b0);
    stall_at = cyc + 2;
    stall_len = 5;
    applyStimulus(4'b1100, 1, 0, 1'b0);
    stall_len = 0;
    applyStimulus(4'b1111, 0, 0, 1'b0);
    applyStimulus(4'b1001, 3, 2, 1'b1);

    // Abort a transfer with reset mid-SEND; no done pulse may follow.
    start = 1'b1;
    pattern = 4'b1011;
    rep = 8'd3;
    gap = 4'd1;
    sb.push_back('{4'b1011, 3, 1, cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(4'b1010, 1, 0, 1'b0);

    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      applyStimulus(PAT_W'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
    end
    rand_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size() + int'(active), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter: the source-side counterpart of the team's serial sequence detectors. On a start pulse it captures a PAT_W-bit pattern and shifts it out MSB-first on a one-bit serial stream. The pattern is repeated `rep` times, with an optional idle gap between repetitions. Output bits use a valid/ready handshake, so a detector or any other bit-serial sink can throttle the stream.

## Interface
- PAT_W, 4, pattern width in bits (≥2)
- REP_W, 8, width of repetition count
- GAP_W, 4, width of inter-repetition gap length
- DEF_PAT, 4'b1010, pattern value reset into the pattern register
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset; one clock domain, async assert
- start  input  1  request pulse; sampled only in IDLE
- pattern  input  PAT_W  pattern to send, captured on accepted start
- rep  input  REP_W  number of repetitions, captured on accepted start
- gap  input  GAP_W  idle cycles between repetitions, captured on accepted start
- out_bit  output  1  current serial bit
- out_valid  output  1  out_bit is valid
- out_ready  input  1  sink accepts out_bit this cycle
- busy  output  1  high in SEND, GAP, DONE
- done  output  1  one-cycle pulse after the last bit is accepted

## Operation
- FSM states: IDLE, SEND, GAP, DONE. Binary encoded, 2 bits.
- Registers:
  - pat_r (PAT_W)
  - bit_idx (clog2 PAT_W)
  - reps_left (REP_W)
  - gap_r (GAP_W)
  - gap_cnt (GAP_W)
- IDLE:
  - start=1 captures pattern/rep/gap.
  - rep≠0 → SEND, with bit_idx=PAT_W-1 and reps_left=rep.
  - rep=0 → DONE; no bit is ever valid.
- SEND:
  - out_valid=1, out_bit=pat_r[bit_idx].
  - Advance only on out_valid&out_ready (accept).
  - Accept with bit_idx>0 → bit_idx-1.
  - Accept with bit_idx=0 and reps_left=1 → DONE.
  - Accept with bit_idx=0 and reps_left>1:
    - reps_left-1, bit_idx=PAT_W-1.
    - gap_r=0 → stay in SEND (back-to-back repetitions).
    - gap_r≠0 → GAP, with gap_cnt=gap_r.
- GAP:
  - out_valid=0, out_bit=0.
  - gap_cnt decrements each cycle; at gap_cnt=1 → SEND.
  - Total GAP dwell = gap_r cycles. out_ready is ignored.
- DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored, including during the DONE cycle. Inputs are not re-sampled mid-transfer.
- out_bit/out_valid/busy/done depend only on state and registers; there is no combinational path from out_ready or start.
- Reset values:
  - state=IDLE, pat_r=DEF_PAT, all counters 0.
  - out_bit=0, out_valid=0, busy=0, done=0.
- Reset mid-operation: outputs go to reset values immediately (async). The stream is truncated with no done pulse. First start after deassertion behaves normally.

## Timing
- Start accepted at edge k → out_valid=1 with the first (MSB) bit in the cycle after edge k.
- With out_ready held 1 and gap=0, PAT_W·rep bits are sent on consecutive cycles.
- done is asserted in the cycle after the final accept. busy drops the cycle after done.
- A stall (out_ready=0) holds out_bit and out_valid stable indefinitely.
- Minimum start-to-start spacing: PAT_W·rep + (rep-1)·gap + 2 cycles.

## Structure
- Shared package pattern_tx_pkg holds:
  - state encoding constants (IDLE=0, SEND=1, GAP=2, DONE=3)
  - the DEF_PAT default
- One natural sub-module, down_cnt: a loadable down-counter with a zero flag, parameterised by width. It is instantiated for bit_idx, reps_left and gap_cnt.

## Test plan
- pattern=1010, rep=2, gap=0, ready=1 → out_bit 1,0,1,0,1,0,1,0 on 8 consecutive valid cycles starting 1 cycle after start; done pulse on the 9th; busy low after.
- pattern=1010, rep=2, gap=3 → 1010, then 3 cycles with out_valid=0 and out_bit=0, then 1010, then done.
- pattern=1100, rep=1, ready low for 5 cycles on the second bit → out_bit=1 and out_valid=1 held through the stall; exactly 4 accepts total; done once.
- rep=0 → no out_valid ever; done pulses exactly 1 cycle after start; busy high for that one cycle only.
- start re-pulsed during SEND with pattern=0110 → ignored; original pattern completes unchanged.
- rst asserted mid-SEND → out_valid/busy/done fall immediately, no done pulse. Next start with 1010, rep=1 sends 1,0,1,0 correctly.
